// File: rtl/rescale_arbiter.sv
// ---------------------------------------------------------------------------
// rescale_arbiter
//
// Purpose:
//   Shares one external Rescale pipeline (multiply by M0, shift by N,
//   saturate to int8) among NUM_REQ requesters. One 32-bit accumulator per
//   cycle is round-robin granted into the pipeline. A tag shift register of
//   PIPE_LAT stages follows each item so its int8 result leaves on a single
//   valid/ready output together with the id of the requester it belongs to.
//   Backpressure freezes the tag pipe and the shared unit via rs_en.
//
// Optional build feature:
//   RESCALE_ARB_PRIO_EN - when defined, requester 0 (bias/priority channel)
//   has strict priority and its grants leave the round-robin pointer alone.
//   When undefined, arbitration is pure round-robin over all requesters.
//
// Ports:
//   clk          clock
//   rst_b        synchronous reset, active-high
//   req_valid    per-requester data valid
//   req_data     per-requester signed accumulators, requester i at [32*i +: 32]
//   req_ready    one-hot grant (combinational)
//   rs_en        enable to the shared Rescale pipeline
//   rs_data_in   accumulator issued to the pipeline (0 when no grant)
//   rs_data_out  signed int8 result from the pipeline
//   out_valid    result valid
//   out_id       requester id of the result
//   out_data     signed int8 result
//   out_ready    downstream accept
//   busy         at least one item in flight
// ---------------------------------------------------------------------------
module rescale_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rs_en,
  output logic [31:0]             rs_data_in,
  input  logic [7:0]              rs_data_out,
  output logic                    out_valid,
  output logic [ID_W-1:0]         out_id,
  output logic [7:0]              out_data,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int LAST = PIPE_LAT - 1;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  tag_t [PIPE_LAT-1:0] tag_q, tag_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  above_ptr;
  logic [ID_W-1:0]     rr_id;
  logic                prio_hit;
  logic                gnt;
  logic [ID_W-1:0]     gnt_id;

  // The whole pipe freezes only while the head result waits for acceptance;
  // accepting the head and granting a new item in the same cycle is allowed.
  assign rs_en = !(tag_q[LAST].v && !out_ready);

  // Round-robin pick: the lowest valid index at or above the pointer wins;
  // if none exists the search wraps and the lowest valid index overall wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    above_ptr = '0;
    rr_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_ptr[i] = req_valid[i] && (ID_W'(i) >= ptr_q);
    end
    // Scan high-to-low so the lowest qualifying index is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) rr_id = ID_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (above_ptr[i]) rr_id = ID_W'(i);
    end
  end

  // Grant decision. No grant while stalled or while reset is asserted.
  always_comb begin
`ifdef RESCALE_ARB_PRIO_EN
    prio_hit = req_valid[0];
`else
    prio_hit = 1'b0;
`endif
    gnt    = 1'b0;
    gnt_id = '0;
    if (rs_en && !rst_b) begin
      if (prio_hit) begin
        gnt    = 1'b1;
        gnt_id = '0;
      end else if (|req_valid) begin
        gnt    = 1'b1;
        gnt_id = rr_id;
      end
    end
  end

  // Pointer moves past the granted requester; priority grants leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt && !prio_hit) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // One-hot ready and the data mux into the shared unit.
  always_comb begin
    req_ready  = '0;
    rs_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt && (gnt_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        rs_data_in   = req_data[32*i +: 32];
      end
    end
  end

  // Tag pipe mirrors the shared unit's stages: it shifts exactly when the
  // unit does, so the head tag always describes rs_data_out.
  always_comb begin
    tag_d = tag_q;
    if (rs_en) begin
      tag_d[0] = '{v: gnt, id: gnt_id};   // gnt_id is 0 on a bubble
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < PIPE_LAT; k++) begin
      busy = busy | tag_q[k].v;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      tag_q <= '0;
      ptr_q <= '0;
    end else begin
      tag_q <= tag_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = tag_q[LAST].v;
  assign out_id    = tag_q[LAST].id;
  assign out_data  = rs_data_out;

endmodule

// File: tb/tb_rescale_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rescale_arbiter
//
// Self-checking bench for rescale_arbiter (NUM_REQ=4, ID_W=2, PIPE_LAT=2).
// Contains a stand-in for the shared Rescale unit (M0=59, N=11, saturate to
// int8, two enabled register stages) and a behavioural model: a queue of
// granted items in grant order, each stamped with the count of enabled
// cycles at grant time; the head is presentable once PIPE_LAT enabled
// cycles have passed. A monitor compares the DUT to the model every cycle.
// Honors RESCALE_ARB_PRIO_EN for the priority variant.
// ---------------------------------------------------------------------------
module tb_rescale_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int PIPE_LAT = 2;
  localparam longint M0   = 59;
  localparam int N_SH     = 11;
`ifdef RESCALE_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_b = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [32*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rs_en;
  logic [31:0]           rs_data_in;
  logic [7:0]            rs_data_out;
  logic                  out_valid;
  logic [ID_W-1:0]       out_id;
  logic [7:0]            out_data;
  logic                  out_ready = 1'b0;
  logic                  busy;

  always #5 clk = ~clk;

  rescale_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rs_en      (rs_en),
    .rs_data_in (rs_data_in),
    .rs_data_out(rs_data_out),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  function automatic logic [7:0] rescale(input logic [31:0] a);
    longint p;
    p = (longint'(signed'(a)) * M0) >>> N_SH;
    if (p > 127)  return 8'h7F;
    if (p < -128) return 8'h80;
    return 8'(p);
  endfunction

  // Shared Rescale unit stand-in: holds its registers when rs_en=0.
  logic [7:0] s0 = '0, s1 = '0;
  always @(posedge clk) begin
    if (rs_en) begin
      s0 <= rescale(rs_data_in);
      s1 <= s0;
    end
  end
  assign rs_data_out = s1;

  // ---------------- checking infrastructure ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          id;
    logic [31:0] data;
    longint      stamp;
  } item_t;

  item_t  q[$];
  int     mptr   = 0;
  longint en_cnt = 0;
  bit     chk_en = 1'b0;

  logic               exp_ov, exp_en, exp_gnt;
  int                 exp_gid;
  logic [NUM_REQ-1:0] exp_ready;
  logic [31:0]        exp_rs_in;
  int                 n_gnt_obs = 0;
  int                 n_res_obs = 0;

  always @(negedge clk) begin
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (en_cnt - q[0].stamp) >= PIPE_LAT;
    exp_en  = !(exp_ov && !out_ready);
    exp_gnt = 1'b0;
    exp_gid = 0;
    if (exp_en && !rst_b) begin
      if (PRIO && req_valid[0]) begin
        exp_gnt = 1'b1;
        exp_gid = 0;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int idx;
          idx = (mptr + k) % NUM_REQ;
          if (!exp_gnt && req_valid[idx]) begin
            exp_gnt = 1'b1;
            exp_gid = idx;
          end
        end
      end
    end
    exp_ready = exp_gnt ? (NUM_REQ'(1) << exp_gid) : '0;
    exp_rs_in = exp_gnt ? req_data[32*exp_gid +: 32] : 32'h0;

    if (chk_en) begin
      check("req_ready",  req_ready,  exp_ready);
      check("rs_en",      rs_en,      exp_en);
      check("rs_data_in", rs_data_in, exp_rs_in);
      check("out_valid",  out_valid,  exp_ov);
      check("busy",       busy,       q.size() > 0);
      if (exp_ov) begin
        logic [7:0] ed;
        ed = rescale(q[0].data);
        check("out_id",   out_id,   q[0].id);
        check("out_data", out_data, ed);
      end
      n_gnt_obs += $countones(req_valid & req_ready);
      if (out_valid && out_ready) n_res_obs++;
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      q.delete();
      mptr   = 0;
      en_cnt = 0;
      chk_en = 1'b1;
    end else begin
      if (exp_ov && out_ready) void'(q.pop_front());
      if (exp_gnt) begin
        q.push_back('{id: exp_gid, data: req_data[32*exp_gid +: 32], stamp: en_cnt});
        if (!(PRIO && exp_gid == 0)) mptr = (exp_gid + 1) % NUM_REQ;
      end
      if (exp_en) en_cnt++;
    end
  end

  // ---------------- driver helpers ----------------
  logic [NUM_REQ-1:0] last_g = '0;
  logic               last_ov, last_acc, last_busy, last_en;
  logic [ID_W-1:0]    last_id;
  logic [7:0]         last_data;

  // Samples the current cycle's DUT outputs, then advances to just after
  // the next rising edge where new inputs may be driven.
  task automatic tick();
    @(negedge clk);
    #1;
    last_g    = req_valid & req_ready;
    last_ov   = out_valid;
    last_acc  = out_valid && out_ready;
    last_busy = busy;
    last_en   = rs_en;
    last_id   = out_id;
    last_data = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[32*i +: 32] = v;
  endtask

  task automatic do_reset();
    rst_b     = 1'b1;
    req_valid = '0;
    tick();
    rst_b  = 1'b0;
    last_g = '0;
  endtask

  function automatic logic [31:0] rnd_acc();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 200000)) - 32'd100000;
      2:       return ($urandom % 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'($urandom_range(0, 70000));
    endcase
  endfunction

  task automatic drain(input string name);
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!last_busy) break;
    end
    check(name, last_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int j;
    int nres;
    int g0, r0;
    logic [ID_W-1:0] held_id;
    logic [7:0]      held_data;

    // ---- 1: single requester, latency and value ----
    do_reset();
    out_ready = 1'b1;
    set_data(2, 32'd1000);
    req_valid = 4'b0100;
    tick();
    check("t1_grant", last_g, 4'b0100);
    req_valid = '0;
    tick();
    check("t1_not_early", last_ov, 1'b0);
    tick();
    check("t1_valid", last_ov, 1'b1);
    check("t1_id",    last_id, 2'd2);
    check("t1_data",  last_data, 8'd28);
    tick();
    check("t1_idle", last_busy, 1'b0);

    // ---- 2 / 6: all valid, then requester 0 dropped ----
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, rnd_acc());
    req_valid = 4'hF;
    j = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t2_grant", last_g, PRIO ? 4'b0001 : (4'b0001 << (k % 4)));
      if (last_acc) begin
        check("t2_res_id", last_id, PRIO ? 2'd0 : ID_W'(j % 4));
        j++;
      end
      for (int i = 0; i < NUM_REQ; i++) if (last_g[i]) set_data(i, rnd_acc());
    end
    req_valid = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_rotate", last_g, 4'b0010 << (k % 3));
      for (int i = 0; i < NUM_REQ; i++) if (last_g[i]) set_data(i, rnd_acc());
    end
    drain("t2_drain");

    // ---- 3: backpressure ----
    do_reset();
    g0 = n_gnt_obs;
    r0 = n_res_obs;
    out_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) if (last_g[i]) set_data(i, rnd_acc());
    end
    out_ready = 1'b0;
    tick();
    check("t3_stall_en",    last_en, 1'b0);
    check("t3_stall_ready", last_g,  4'b0000);
    held_id   = last_id;
    held_data = last_data;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_stall_en",    last_en,   1'b0);
      check("t3_stall_ready", last_g,    4'b0000);
      check("t3_hold_id",     last_id,   held_id);
      check("t3_hold_data",   last_data, held_data);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) if (last_g[i]) set_data(i, rnd_acc());
    end
    drain("t3_drain");
    check("t3_count", n_res_obs - r0, n_gnt_obs - g0);

    // ---- 4: saturation ----
    do_reset();
    out_ready = 1'b1;
    set_data(1, 32'h7FFF_FFFF);
    req_valid = 4'b0010;
    tick();
    check("t4_grant0", last_g, 4'b0010);
    set_data(1, 32'h8000_0000);
    tick();
    check("t4_grant1", last_g, 4'b0010);
    req_valid = '0;
    nres = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (last_acc) begin
        check("t4_id", last_id, 2'd1);
        check("t4_data", last_data, (nres == 0) ? 8'h7F : 8'h80);
        nres++;
      end
    end
    check("t4_count", nres, 2);

    // ---- 5: reset with items in flight ----
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'hF;
    tick();
    tick();
    req_valid = '0;
    tick();
    check("t5_in_flight", last_busy, 1'b1);
    rst_b = 1'b1;
    tick();
    rst_b     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1010;
    tick();
    check("t5_no_stale", last_ov, 1'b0);
    check("t5_grant",    last_g,  4'b0010);
    req_valid = '0;
    nres = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (last_acc) begin
        check("t5_res_id", last_id, 2'd1);
        nres++;
      end
    end
    check("t5_count", nres, 1);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_g[i]) begin
          req_valid[i] = ($urandom % 4) != 0;
          set_data(i, rnd_acc());
        end else if (req_valid[i]) begin
          if ($urandom % 16 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req_valid[i] = 1'b1;
          set_data(i, rnd_acc());
        end
      end
      out_ready = ($urandom % 4) != 0;
      rst_b     = (cyc == 1200);
      tick();
    end
    rst_b = 1'b0;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
